sram_arbiter: RTL and testbench

//   Shares the single external SRAM between the SLC-3 CPU memory port and the program loader (DMA) port.

---
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one external SRAM between the CPU port and the loader port.
// Latency: request sampled at edge k, ack high for the one cycle after edge k+WAIT_CYC+1.
// Backpressure: req held until its one-cycle ack; one access in flight, the other waits.
module sram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              grant_ldr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last;      // owner of the most recent grant (1 = loader)
  logic       owner;     // owner of the access in flight
  logic       acc_we;    // latched direction of the access in flight
  logic       pick_ldr;

  // Loader wins when it is alone, or when both ask and the CPU had the last turn.
  always_comb begin
    pick_ldr = ldr_req && (!cpu_req || !last);
  end

  assign grant_ldr = owner;
  assign busy      = (state != IDLE);

  // Access sequencer: all SRAM strobes, acks and read data are registered here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      owner       <= 1'b0;
      acc_we      <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
      cpu_rdata   <= '0;
      ldr_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            owner       <= pick_ldr;
            last        <= pick_ldr;
            acc_we      <= pick_ldr ? ldr_we : cpu_we;
            SRAM_ADDR   <= pick_ldr ? ldr_addr : cpu_addr;
            SRAM_DQ_out <= pick_ldr ? ldr_wdata : cpu_wdata;
            SRAM_DQ_oe  <= pick_ldr ? ldr_we : cpu_we;
            SRAM_CE_N   <= 1'b0;
            cnt         <= 4'(WAIT_CYC - 1);
            state       <= SETUP;
          end
        end
        SETUP: begin
          // Address has been stable for a full cycle before any strobe goes low.
          if (acc_we) SRAM_WE_N <= 1'b0;
          else        SRAM_OE_N <= 1'b0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            if (!acc_we) begin
              if (owner) ldr_rdata <= SRAM_DQ_in;
              else       cpu_rdata <= SRAM_DQ_in;
            end
            if (owner) ldr_ack <= 1'b1;
            else       cpu_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Data stays driven through DONE to give the SRAM write hold time.
          cpu_ack    <= 1'b0;
          ldr_ack    <= 1'b0;
          SRAM_CE_N  <= 1'b1;
          SRAM_DQ_oe <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance at WAIT_CYC=2, one at WAIT_CYC=1.
// Each instance talks to its own behavioural SRAM model.
// Strobe activity is counted on the falling clock edge.
module tb_sram_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  // instance A (WAIT_CYC = 2)
  logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic cpu_ack, ldr_ack, dq_oe, ce_n, oe_n, we_n, grant_ldr, busy;
  logic [15:0] cpu_rdata, ldr_rdata, sram_addr, dq_out, dq_in;

  // instance B (WAIT_CYC = 1)
  logic b_cpu_req = 0, b_cpu_we = 0, b_ldr_req = 0, b_ldr_we = 0;
  logic [15:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_ldr_addr = 0, b_ldr_wdata = 0;
  logic b_cpu_ack, b_ldr_ack, b_dq_oe, b_ce_n, b_oe_n, b_we_n, b_grant_ldr, b_busy;
  logic [15:0] b_cpu_rdata, b_ldr_rdata, b_sram_addr, b_dq_out, b_dq_in;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(2)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .SRAM_ADDR(sram_addr), .SRAM_DQ_out(dq_out), .SRAM_DQ_oe(dq_oe), .SRAM_DQ_in(dq_in),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .grant_ldr(grant_ldr), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(1)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
    .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
    .SRAM_ADDR(b_sram_addr), .SRAM_DQ_out(b_dq_out), .SRAM_DQ_oe(b_dq_oe), .SRAM_DQ_in(b_dq_in),
    .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n),
    .grant_ldr(b_grant_ldr), .busy(b_busy)
  );

  // SRAM models: unwritten words return a fixed pattern so no preload writes are needed.
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  bit          wr_a  [0:1023];
  bit          wr_b  [0:1023];

  function automatic logic [15:0] init_pat(input logic [15:0] a);
    case (a)
      16'h0040: return 16'h1234;
      16'h0010: return 16'hA5A5;
      default:  return ~a;
    endcase
  endfunction

  assign dq_in   = (!ce_n && !oe_n) ?
                   (wr_a[sram_addr[9:0]] ? mem_a[sram_addr[9:0]] : init_pat(sram_addr)) : 16'h0000;
  assign b_dq_in = (!b_ce_n && !b_oe_n) ?
                   (wr_b[b_sram_addr[9:0]] ? mem_b[b_sram_addr[9:0]] : init_pat(b_sram_addr)) : 16'h0000;

  always @(posedge Clk) begin
    if (!ce_n && !we_n && dq_oe) begin
      mem_a[sram_addr[9:0]] <= dq_out;
      wr_a[sram_addr[9:0]]  <= 1'b1;
    end
    if (!b_ce_n && !b_we_n && b_dq_oe) begin
      mem_b[b_sram_addr[9:0]] <= b_dq_out;
      wr_b[b_sram_addr[9:0]]  <= 1'b1;
    end
  end

  // cumulative activity counters, compared as deltas around each scenario
  int a_oe_lo = 0, a_we_lo = 0, a_dqoe = 0, a_cack = 0, a_lack = 0, a_both = 0, a_own_bad = 0;
  int b_oe_lo = 0, b_we_lo = 0;

  always @(negedge Clk) begin
    if (!oe_n)  a_oe_lo++;
    if (!we_n)  a_we_lo++;
    if (dq_oe)  a_dqoe++;
    if (cpu_ack) a_cack++;
    if (ldr_ack) a_lack++;
    if (!oe_n && !we_n) a_both++;
    if ((cpu_ack && grant_ldr) || (ldr_ack && !grant_ldr) || (cpu_ack && ldr_ack)) a_own_bad++;
    if (!b_oe_n) b_oe_lo++;
    if (!b_we_n) b_we_lo++;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
  endtask

  // Ticks until the chosen ack is seen; lat = ticks taken, -1 if the budget expires.
  task automatic wait_ack(input bit on_b, input bit ldr, input int budget, output int lat);
    int  i;
    logic hit;
    i   = 0;
    lat = -1;
    while (lat < 0 && i < budget) begin
      tick();
      i++;
      hit = on_b ? (ldr ? b_ldr_ack : b_cpu_ack) : (ldr ? ldr_ack : cpu_ack);
      if (hit) lat = i;
    end
  endtask

  int lat;
  int s_oe, s_we, s_dq, s_ca, s_la, s_both, s_own;
  int order[$];
  int at[$];

  initial begin
    // reset state, checked while reset is still asserted
    #12;
    chk("rst_ce_n",  ce_n, 1);
    chk("rst_oe_n",  oe_n, 1);
    chk("rst_we_n",  we_n, 1);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_addr",  sram_addr, 0);
    chk("rst_dqout", dq_out, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_grant", grant_ldr, 0);
    chk("rst_acks",  {cpu_ack, ldr_ack}, 0);
    chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    // CPU read of 0x0040
    s_oe = a_oe_lo; s_ca = a_cack; s_la = a_lack;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    tick();
    chk("rd_setup_ce", ce_n, 0);
    chk("rd_setup_oe", oe_n, 1);
    chk("rd_setup_addr", sram_addr, 16'h0040);
    chk("rd_setup_busy", busy, 1);
    wait_ack(0, 0, 20, lat);
    chk("rd_lat", lat, 3);
    cpu_req = 0;
    tick(); tick(); tick();
    chk("rd_oe_cycles", a_oe_lo - s_oe, 2);
    chk("rd_cpu_acks", a_cack - s_ca, 1);
    chk("rd_ldr_acks", a_lack - s_la, 0);
    chk("rd_cpu_rdata", cpu_rdata, 16'h1234);
    chk("rd_ldr_rdata", ldr_rdata, 16'h0000);
    chk("rd_idle", busy, 0);

    // loader write 0xBEEF to 0x0100
    s_oe = a_oe_lo; s_we = a_we_lo; s_dq = a_dqoe; s_ca = a_cack; s_la = a_lack;
    ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0100; ldr_wdata = 16'hBEEF;
    wait_ack(0, 1, 20, lat);
    chk("wr_lat", lat, 4);
    ldr_req = 0; ldr_we = 0;
    tick(); tick(); tick();
    chk("wr_we_cycles", a_we_lo - s_we, 2);
    chk("wr_dqoe_cycles", a_dqoe - s_dq, 4);
    chk("wr_oe_cycles", a_oe_lo - s_oe, 0);
    chk("wr_mem", {wr_a[256], mem_a[256]}, {1'b1, 16'hBEEF});
    chk("wr_ldr_acks", a_lack - s_la, 1);
    chk("wr_cpu_acks", a_cack - s_ca, 0);
    chk("wr_keeps_cpu_rdata", cpu_rdata, 16'h1234);
    chk("wr_keeps_ldr_rdata", ldr_rdata, 16'h0000);

    // both requesters rise together after reset and stay up for four accesses
    do_reset();
    s_own = a_own_bad;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0100;
    for (int i = 1; i <= 40 && order.size() < 4; i++) begin
      tick();
      if (cpu_ack) begin order.push_back(0); at.push_back(i); end
      if (ldr_ack) begin order.push_back(1); at.push_back(i); end
    end
    cpu_req = 0; ldr_req = 0;
    chk("rr_count", order.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_owner%0d", k), (order.size() > k) ? order[k] : 99, k % 2);
    chk("rr_first_ack", (at.size() > 0) ? at[0] : -1, 4);
    chk("rr_fourth_ack", (at.size() > 3) ? at[3] : -1, 19);
    tick(); tick();
    chk("rr_ack_owner", a_own_bad - s_own, 0);
    chk("rr_cpu_rdata", cpu_rdata, 16'h1234);
    chk("rr_ldr_rdata", ldr_rdata, 16'hBEEF);

    // reset during the ACCESS phase of a write
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 16'h5555;
    tick(); tick();
    chk("arst_we_before", we_n, 0);
    s_ca = a_cack; s_la = a_lack;
    #2 Reset = 1'b0;
    #1;
    chk("arst_we_n", we_n, 1);
    chk("arst_ce_n", ce_n, 1);
    chk("arst_dq_oe", dq_oe, 0);
    chk("arst_busy", busy, 0);
    cpu_req = 0; cpu_we = 0;
    tick(); tick();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    chk("arst_no_ack", (a_cack - s_ca) + (a_lack - s_la), 0);
    ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0040;
    wait_ack(0, 1, 20, lat);
    chk("arst_next_lat", lat, 4);
    ldr_req = 0;
    tick(); tick();
    chk("arst_next_rdata", ldr_rdata, 16'h1234);

    // requester drops its request in the middle of ACCESS
    s_ca = a_cack;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    tick(); tick();
    cpu_req = 0;
    wait_ack(0, 0, 10, lat);
    chk("drop_lat", lat, 2);
    tick(); tick(); tick();
    chk("drop_acks", a_cack - s_ca, 1);
    chk("drop_rdata", cpu_rdata, 16'hBEEF);
    chk("drop_other_rdata", ldr_rdata, 16'h1234);
    chk("drop_idle", busy, 0);
    chk("never_both_low", a_both, 0);

    // WAIT_CYC=1: CPU read then an immediate CPU write
    s_oe = b_oe_lo; s_we = b_we_lo;
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h0010;
    wait_ack(1, 0, 20, lat);
    chk("w1_rd_lat", lat, 3);
    chk("w1_rd_rdata", b_cpu_rdata, 16'hA5A5);
    b_cpu_we = 1; b_cpu_wdata = 16'h0F0F;
    // first tick only leaves DONE; the write is sampled on the second
    wait_ack(1, 0, 20, lat);
    chk("w1_wr_lat", lat, 4);
    b_cpu_req = 0; b_cpu_we = 0;
    tick(); tick();
    chk("w1_rdata_kept", b_cpu_rdata, 16'hA5A5);
    chk("w1_mem", {wr_b[16], mem_b[16]}, {1'b1, 16'h0F0F});
    chk("w1_oe_cycles", b_oe_lo - s_oe, 1);
    chk("w1_we_cycles", b_we_lo - s_we, 1);
    chk("w1_ldr_rdata", b_ldr_rdata, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
